// File: rtl/lae_pkg.sv
// lae_pkg: shared types and constants for the LAE stream host.
//   W       - share width of one data word (core rate, fixed)
//   TW      - tag share width
//   SHARES  - number of Boolean shares per word
//   state_t - host FSM states
//   in_entry_t - one input FIFO entry {d1..d4, isad, last}
package lae_pkg;

    localparam int W      = 10;
    localparam int TW     = 80;
    localparam int SHARES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        TAG   = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] d3;
        logic [W-1:0] d4;
        logic         isad;
        logic         last;
    } in_entry_t;

endpackage

// File: rtl/lae_stream_host_if.sv
// lae_stream_host_if: upstream word stream (s_*) and downstream ciphertext
// stream (m_*) of the LAE stream host.
//   slave  - host side: consumes s_* words, produces m_* words
//   master - environment side: produces s_* words, consumes m_* words
interface lae_stream_host_if;
    import lae_pkg::*;

    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_d1, s_d2, s_d3, s_d4;
    logic         s_isad;
    logic         s_last;

    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_c1, m_c2, m_c3, m_c4;

    modport slave (
        input  s_valid, s_d1, s_d2, s_d3, s_d4, s_isad, s_last, m_ready,
        output s_ready, m_valid, m_c1, m_c2, m_c3, m_c4
    );

    modport master (
        output s_valid, s_d1, s_d2, s_d3, s_d4, s_isad, s_last, m_ready,
        input  s_ready, m_valid, m_c1, m_c2, m_c3, m_c4
    );

endinterface

// File: rtl/lae_share_fifo.sv
// lae_share_fifo: small synchronous FIFO for share words.
//   ck, rst      - clock, synchronous active-high reset (flushes pointers)
//   push, wdata  - write request; accepted when not full, or when full with
//                  a same-cycle pop (the freed slot is reused)
//   pop, rdata   - read request; rdata is the current head (valid if !empty)
//   full, empty  - status, from pointers carrying an extra wrap bit
module lae_share_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic push_ok, pop_ok;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        wr_d    = wr_q;
        rd_d    = rd_q;
        mem_d   = mem_q;
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = wdata;
            wr_d = wr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_d = rd_q + PTR_ONE;
        end
    end

    assign rdata = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: the head is only observed while non-empty.
    always_ff @(posedge ck) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/lae_stream_host.sv
// lae_stream_host: host-side feeder/collector for the FIDES-160 threshold
// LAE core's getdata/outc/final_o stream protocol.
//   ck, rst          - clock, synchronous active-high reset
//   go               - one-cycle message start request (ignored unless idle)
//   s (slave)        - upstream words s_*, downstream ciphertext words m_*
//   start            - one-cycle core start, issued once the first word is buffered
//   inp1..4,Ain,Min,last - head of the input FIFO, zeros when empty
//   getdata          - core consumes the head this cycle (core never stalls)
//   outc, cout1..4   - core ciphertext word, captured into the output FIFO
//   final_o, Tin1..4 - core tag shares, latched into tag1..4
//   tag_valid, busy, err - tag held, FSM active, sticky underrun/overflow
module lae_stream_host
    import lae_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                ck,
    input  logic                rst,
    input  logic                go,
    lae_stream_host_if.slave    s,
    output logic                start,
    output logic [W-1:0]        inp1, inp2, inp3, inp4,
    output logic                Ain,
    output logic                Min,
    output logic                last,
    input  logic                getdata,
    input  logic                outc,
    input  logic                final_o,
    input  logic [W-1:0]        cout1, cout2, cout3, cout4,
    input  logic [TW-1:0]       Tin1, Tin2, Tin3, Tin4,
    output logic [TW-1:0]       tag1, tag2, tag3, tag4,
    output logic                tag_valid,
    output logic                busy,
    output logic                err
);

    state_t state_q, state_d;
    logic   tag_valid_q, tag_valid_d;
    logic   last_acc_q, last_acc_d;
    logic   err_q, err_d;
    logic [SHARES-1:0][TW-1:0] tag_q, tag_d;

    in_entry_t in_wdata, in_head;
    logic in_push, in_pop, in_full, in_empty;
    logic [SHARES*W-1:0] out_wdata, out_head;
    logic out_full, out_empty, out_pop;

    // ---------------- input FIFO ----------------
    assign s.s_ready = !in_full && (state_q != IDLE) && !last_acc_q;
    assign in_push   = s.s_valid && s.s_ready;
    assign in_pop    = getdata && !in_empty;
    assign in_wdata  = '{d1: s.s_d1, d2: s.s_d2, d3: s.s_d3, d4: s.s_d4,
                         isad: s.s_isad, last: s.s_last};

    lae_share_fifo #(.WIDTH($bits(in_entry_t)), .DEPTH(DEPTH)) u_in_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (in_push),
        .pop   (in_pop),
        .wdata (in_wdata),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    // The core samples these whenever it raises getdata; an empty FIFO
    // must look like all-zero data rather than stale storage.
    always_comb begin
        inp1 = '0;
        inp2 = '0;
        inp3 = '0;
        inp4 = '0;
        Ain  = 1'b0;
        Min  = 1'b0;
        last = 1'b0;
        if (!in_empty) begin
            inp1 = in_head.d1;
            inp2 = in_head.d2;
            inp3 = in_head.d3;
            inp4 = in_head.d4;
            Ain  = in_head.isad;
            Min  = !in_head.isad;
            last = in_head.last;
        end
    end

    // ---------------- output FIFO ----------------
    assign out_wdata = {cout1, cout2, cout3, cout4};
    assign out_pop   = !out_empty && s.m_ready;

    lae_share_fifo #(.WIDTH(SHARES*W), .DEPTH(DEPTH)) u_out_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (outc),
        .pop   (out_pop),
        .wdata (out_wdata),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    assign s.m_valid = !out_empty;
    assign s.m_c1    = out_empty ? '0 : out_head[4*W-1 -: W];
    assign s.m_c2    = out_empty ? '0 : out_head[3*W-1 -: W];
    assign s.m_c3    = out_empty ? '0 : out_head[2*W-1 -: W];
    assign s.m_c4    = out_empty ? '0 : out_head[W-1 -: W];

    // ---------------- control FSM ----------------
    always_comb begin
        state_d     = state_q;
        tag_valid_d = tag_valid_q;
        last_acc_d  = last_acc_q;
        tag_d       = tag_q;
        start       = 1'b0;
        // Underrun (core pulls from empty FIFO) or overflow (word dropped
        // because the output FIFO is full and nothing leaves this cycle).
        err_d = err_q | (getdata && in_empty) | (outc && out_full && !out_pop);

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d     = PRIME;
                    tag_valid_d = 1'b0;
                    last_acc_d  = 1'b0;
                end
            end
            PRIME: begin
                // Hold off start until data is buffered so the core's
                // first getdata cannot underrun.
                if (!in_empty) begin
                    start   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (in_pop && in_head.last && !in_head.isad) begin
                    state_d = TAG;
                end
            end
            TAG: begin
                if (final_o) begin
                    tag_d       = {Tin4, Tin3, Tin2, Tin1};
                    tag_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Closing the upstream after the final message word keeps the next
        // message's words from mixing into this one.
        if (in_push && !s.s_isad && s.s_last) begin
            last_acc_d = 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q     <= IDLE;
            tag_valid_q <= 1'b0;
            last_acc_q  <= 1'b0;
            err_q       <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            tag_valid_q <= tag_valid_d;
            last_acc_q  <= last_acc_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
        end
    end

    assign tag1      = tag_q[0];
    assign tag2      = tag_q[1];
    assign tag3      = tag_q[2];
    assign tag4      = tag_q[3];
    assign tag_valid = tag_valid_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule
